// File: rtl/dsc_fifo_pkg.sv
// dsc_fifo_pkg: width and latency constants shared by the descriptor FIFO and its read-side streamer.
//   DSC_DATA_WIDTH  - FIFO word / stream data width
//   DSC_RD_LATENCY  - default FIFO read latency in cycles
//   credit_width()  - bits needed to hold a credit count of 0..rd_latency+1
package dsc_fifo_pkg;

    localparam int DSC_DATA_WIDTH = 8;
    localparam int DSC_RD_LATENCY = 1;

    function automatic int credit_width(input int rd_latency);
        return $clog2(rd_latency + 2);
    endfunction

endpackage

// File: rtl/stream_obuf.sv
// stream_obuf: small circular output buffer; the head entry is presented combinationally.
//   clk, rst_n     - clock, asynchronous active-low reset (clears contents, indices, count)
//   wr_en, wr_data - push one word at the tail
//   pop            - drop the head word (caller guarantees count != 0)
//   head           - oldest stored word
//   count          - number of stored words
module stream_obuf #(
    parameter int DW    = 8,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [CW-1:0] count
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    // Indices wrap at DEPTH, which need not be a power of two.
    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
        return (i == IW'(DEPTH - 1)) ? '0 : i + IW'(1);
    endfunction

    assign head = mem[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '{default: '0};
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_idx] <= wr_data;
                wr_idx      <= nxt(wr_idx);
            end
            if (pop)
                rd_idx <= nxt(rd_idx);
            // Simultaneous write and pop leave the count unchanged.
            count <= count + CW'(wr_en) - CW'(pop);
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pops a fixed-latency FIFO and presents its words as a valid/ready stream.
//   clk, rst_n     - clock, asynchronous active-low reset
//   fifo_empty_i   - upstream FIFO empty flag
//   fifo_data_i    - upstream FIFO read data, valid RD_LATENCY cycles after a pop
//   fifo_rd_en_o   - single-cycle pop strobe
//   m_valid_o, m_data_o, m_ready_i - output stream
//   busy_o         - a pop is in flight or a word is buffered
//   beat_cnt_o     - accepted-beat counter, present only with FIFO_RD_STREAM_STATS_EN defined
module fifo_rd_stream
    import dsc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DSC_DATA_WIDTH,
    parameter int RD_LATENCY = DSC_RD_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_rd_en_o,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    input  logic                  m_ready_i,
    output logic                  busy_o
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [31:0]           beat_cnt_o
`endif
);

    localparam int CAP = RD_LATENCY + 1;
    localparam int CW  = credit_width(RD_LATENCY);

    logic                  accept;
    logic                  capture;
    logic [CW-1:0]         credit;
    logic [CW-1:0]         count;
    logic [RD_LATENCY-1:0] inflight;

    assign accept = m_valid_o & m_ready_i;
    // A beat leaving this cycle frees its slot in time for a pop issued this cycle.
    // Gating with rst_n keeps the strobe low for the whole reset pulse.
    assign fifo_rd_en_o = rst_n && !fifo_empty_i && (credit != '0 || accept);
    assign capture      = inflight[RD_LATENCY-1];
    assign m_valid_o    = count != '0;
    assign busy_o       = m_valid_o || (|inflight);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit   <= CW'(CAP);
            inflight <= '0;
        end else begin
            credit   <= credit - CW'(fifo_rd_en_o) + CW'(accept);
            inflight <= RD_LATENCY'({inflight, fifo_rd_en_o});
        end
    end

    stream_obuf #(
        .DW    (DATA_WIDTH),
        .DEPTH (CAP),
        .CW    (CW)
    ) u_obuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (capture),
        .wr_data (fifo_data_i),
        .pop     (accept),
        .head    (m_data_o),
        .count   (count)
    );

`ifdef FIFO_RD_STREAM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            beat_cnt_o <= '0;
        else if (accept)
            beat_cnt_o <= beat_cnt_o + 32'd1;
    end
`endif

endmodule
